// File: rtl/msrv32_store_unit.sv
// RV32I store unit: aligns SB/SH/SW data onto byte lanes, builds the write strobes and
// drives AHB-Lite address-phase control. Optional macro: STORE_MISALIGN_CHK_EN.
module msrv32_store_unit (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [1:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        mem_wr_req_in,
    input  logic        ahb_ready_in,
    output logic [31:0] d_addr_out,
    output logic [31:0] data_out,
    output logic [3:0]  wr_mask_out,
    output logic [1:0]  ahb_htrans_out,
    output logic        wr_req_out,
    output logic        misaligned_out
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]  off_s;
    logic [31:0] addr_d, addr_q;
    logic [31:0] data_d, data_q;
    logic [3:0]  lane_mask_s;
    logic [3:0]  mask_d, mask_q;
    logic [1:0]  htrans_d, htrans_q;
    logic        wr_req_d, wr_req_q;
    logic        misaligned_s;
    logic        misaligned_d, misaligned_q;
    logic        issue_s;

    // Next-state computation: lane alignment, strobes and bus control
    always_comb begin
        off_s       = iadder_in[1:0];
        addr_d      = {iadder_in[31:2], 2'b00};
        data_d      = 32'h0000_0000;
        lane_mask_s = 4'b0000;
        case (funct3_in)
            2'b00: begin
                data_d      = {24'h00_0000, rs2_in[7:0]} << {off_s, 3'b000};
                lane_mask_s = 4'b0001 << off_s;
            end
            2'b01: begin
                if (iadder_in[1]) begin
                    data_d      = {rs2_in[15:0], 16'h0000};
                    lane_mask_s = 4'b1100;
                end else begin
                    data_d      = {16'h0000, rs2_in[15:0]};
                    lane_mask_s = 4'b0011;
                end
            end
            default: begin
                data_d      = rs2_in;
                lane_mask_s = 4'b1111;
            end
        endcase
`ifdef STORE_MISALIGN_CHK_EN
        misaligned_s = ((funct3_in == 2'b01) && iadder_in[0]) ||
                       (funct3_in[1] && (off_s != 2'b00));
`else
        misaligned_s = 1'b0;
`endif
        // A misaligned store still loads data/address but never reaches the bus
        issue_s      = mem_wr_req_in && !misaligned_s;
        misaligned_d = mem_wr_req_in && misaligned_s;
        wr_req_d     = issue_s;
        if (issue_s) begin
            mask_d   = lane_mask_s;
            htrans_d = HTRANS_NONSEQ;
        end else begin
            mask_d   = 4'b0000;
            htrans_d = HTRANS_IDLE;
        end
    end

    // Output registers: load only when the bus is ready, hold during stalls
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q       <= 32'h0000_0000;
            data_q       <= 32'h0000_0000;
            mask_q       <= 4'b0000;
            htrans_q     <= HTRANS_IDLE;
            wr_req_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (ahb_ready_in) begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            htrans_q     <= htrans_d;
            wr_req_q     <= wr_req_d;
            misaligned_q <= misaligned_d;
        end else begin
            addr_q       <= addr_q;
            data_q       <= data_q;
            mask_q       <= mask_q;
            htrans_q     <= htrans_q;
            wr_req_q     <= wr_req_q;
            misaligned_q <= misaligned_q;
        end
    end

    assign d_addr_out     = addr_q;
    assign data_out       = data_q;
    assign wr_mask_out    = mask_q;
    assign ahb_htrans_out = htrans_q;
    assign wr_req_out     = wr_req_q;
    assign misaligned_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Directed bench for msrv32_store_unit; expectations adapt to STORE_MISALIGN_CHK_EN.
module tb_msrv32_store_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [1:0]  funct3_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        mem_wr_req_in;
    logic        ahb_ready_in;
    logic [31:0] d_addr_out;
    logic [31:0] data_out;
    logic [3:0]  wr_mask_out;
    logic [1:0]  ahb_htrans_out;
    logic        wr_req_out;
    logic        misaligned_out;

    int checks = 0;
    int errors = 0;

    msrv32_store_unit dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .funct3_in     (funct3_in),
        .iadder_in     (iadder_in),
        .rs2_in        (rs2_in),
        .mem_wr_req_in (mem_wr_req_in),
        .ahb_ready_in  (ahb_ready_in),
        .d_addr_out    (d_addr_out),
        .data_out      (data_out),
        .wr_mask_out   (wr_mask_out),
        .ahb_htrans_out(ahb_htrans_out),
        .wr_req_out    (wr_req_out),
        .misaligned_out(misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [1:0] htrans,
                             input logic wr, input logic mis);
        check({tag, ".addr"},   d_addr_out,             addr);
        check({tag, ".data"},   data_out,               data);
        check({tag, ".mask"},   {28'h0, wr_mask_out},   {28'h0, mask});
        check({tag, ".htrans"}, {30'h0, ahb_htrans_out}, {30'h0, htrans});
        check({tag, ".wr_req"}, {31'h0, wr_req_out},    {31'h0, wr});
        check({tag, ".misal"},  {31'h0, misaligned_out}, {31'h0, mis});
    endtask

    task automatic drive(input logic [1:0] f3, input logic [31:0] addr, input logic [31:0] data,
                         input logic req, input logic rdy);
        funct3_in     = f3;
        iadder_in     = addr;
        rs2_in        = data;
        mem_wr_req_in = req;
        ahb_ready_in  = rdy;
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [3:0]  sb_mask [4];
        logic [31:0] sb_data [4];
        sb_mask[0] = 4'b0001; sb_data[0] = 32'h0000_00A5;
        sb_mask[1] = 4'b0010; sb_data[1] = 32'h0000_A500;
        sb_mask[2] = 4'b0100; sb_data[2] = 32'h00A5_0000;
        sb_mask[3] = 4'b1000; sb_data[3] = 32'hA500_0000;

        // Reset state, observed before any clock edge
        rst_n_in = 1'b0;
        drive(2'b10, 32'h0000_0ABC, 32'h1111_2222, 1'b1, 1'b1);
        #2;
        check_all("reset", 32'h0, 32'h0, 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // SH at odd address
        drive(2'b01, 32'h0000_0001, 32'h1234_5678, 1'b1, 1'b1);
        step();
`ifdef STORE_MISALIGN_CHK_EN
        check_all("sh_odd", 32'h0, 32'h0000_5678, 4'b0000, 2'b00, 1'b0, 1'b1);
`else
        check_all("sh_odd", 32'h0, 32'h0000_5678, 4'b0011, 2'b10, 1'b1, 1'b0);
`endif

        // Stall: outputs hold
        drive(2'b10, 32'h0000_0008, 32'h8765_4321, 1'b0, 1'b0);
        step();
`ifdef STORE_MISALIGN_CHK_EN
        check_all("stall", 32'h0, 32'h0000_5678, 4'b0000, 2'b00, 1'b0, 1'b1);
`else
        check_all("stall", 32'h0, 32'h0000_5678, 4'b0011, 2'b10, 1'b1, 1'b0);
`endif
        ahb_ready_in = 1'b1;
        step();
        check_all("noreq", 32'h8, 32'h8765_4321, 4'b0000, 2'b00, 1'b0, 1'b0);

        // New request during stall is not captured
        drive(2'b10, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 1'b0);
        step();
        check_all("stall_req", 32'h8, 32'h8765_4321, 4'b0000, 2'b00, 1'b0, 1'b0);

        // SB on every byte offset
        for (int i = 3; i >= 0; i--) begin
            drive(2'b00, 32'h0000_0100 + i, 32'h0000_00A5, 1'b1, 1'b1);
            step();
            check_all($sformatf("sb_off%0d", i), 32'h100, sb_data[i], sb_mask[i], 2'b10, 1'b1, 1'b0);
        end

        // SH aligned lower and upper halves
        drive(2'b01, 32'h0000_0012, 32'hAAAA_BEEF, 1'b1, 1'b1);
        step();
        check_all("sh_hi", 32'h10, 32'hBEEF_0000, 4'b1100, 2'b10, 1'b1, 1'b0);
        drive(2'b01, 32'h0000_0014, 32'hAAAA_1234, 1'b1, 1'b1);
        step();
        check_all("sh_lo", 32'h14, 32'h0000_1234, 4'b0011, 2'b10, 1'b1, 1'b0);

        // SW with funct3=11 and a misaligned offset
        drive(2'b11, 32'h0000_0033, 32'h0BAD_C0DE, 1'b1, 1'b1);
        step();
`ifdef STORE_MISALIGN_CHK_EN
        check_all("sw_mis", 32'h30, 32'h0BAD_C0DE, 4'b0000, 2'b00, 1'b0, 1'b1);
`else
        check_all("sw_mis", 32'h30, 32'h0BAD_C0DE, 4'b1111, 2'b10, 1'b1, 1'b0);
`endif

        // Aligned SW then asynchronous reset mid-cycle
        drive(2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();
        check_all("sw", 32'h20, 32'hDEAD_BEEF, 4'b1111, 2'b10, 1'b1, 1'b0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 4'b0000, 2'b00, 1'b0, 1'b0);
        step();
        check_all("rst_held", 32'h0, 32'h0, 4'b0000, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
